// File: rtl/cu_enc_pkg.sv
// Shared types and field constants for the control-unit instruction encoder.
package cu_enc_pkg;

  typedef enum logic [2:0] {
    K_DP_REG = 3'd0,
    K_DP_IMM = 3'd1,
    K_STR    = 3'd2,
    K_LDR    = 3'd3,
    K_B      = 3'd4
  } kind_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [5:0] FN_STR = 6'b011000;
  localparam logic [5:0] FN_LDR = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ENC  = 2'd1,
    S_WR   = 2'd2,
    S_FULL = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [23:0] imm;
  } req_t;

endpackage

// File: rtl/cu_enc_word.sv
// Combinational packer: latched request fields -> 32-bit ARM-format word plus illegal-kind flag.
module cu_enc_word
  import cu_enc_pkg::*;
(
  input  req_t        req,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req.kind)
      K_DP_REG: word = {req.cond, OP_DP, 1'b0, req.cmd, req.s, req.rn, req.rd, 8'h00, req.rm};
      K_DP_IMM: word = {req.cond, OP_DP, 1'b1, req.cmd, req.s, req.rn, req.rd, req.imm[11:0]};
      K_STR:    word = {req.cond, OP_MEM, FN_STR, req.rn, req.rd, req.imm[11:0]};
      K_LDR:    word = {req.cond, OP_MEM, FN_LDR, req.rn, req.rd, req.imm[11:0]};
      K_B:      word = {req.cond, OP_BR, 2'b10, req.imm[23:0]};
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_instr_encoder.sv
// Request handshake, encode FSM and sequential instruction-memory writer.
// Optional CU_ENC_CHECK_EN adds chk_err: Op/Funct re-decode of the word being written.
module cu_instr_encoder
  import cu_enc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [3:0]        req_cond,
  input  logic [3:0]        req_cmd,
  input  logic              req_s,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rm,
  input  logic [23:0]       req_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_wr_ready,
  output logic              enc_err,
  output logic              full,
  output logic [ADDR_W:0]   word_count
`ifdef CU_ENC_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  state_e      state;
  req_t        req_q;
  logic [31:0] enc_word;
  logic        enc_illegal;

  cu_enc_word u_word (
    .req     (req_q),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

`ifdef CU_ENC_CHECK_EN
  // Mirrors the main decoder's view of Op/Funct for the word on the bus.
  logic chk_bad;
  always_comb begin
    chk_bad = 1'b0;
    case (im_wdata[27:26])
      OP_DP:   chk_bad = im_wdata[25] != (req_q.kind == K_DP_IMM);
      OP_MEM:  chk_bad = im_wdata[20] != (req_q.kind == K_LDR);
      OP_BR:   chk_bad = req_q.kind != K_B;
      default: chk_bad = 1'b0;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      enc_err    <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
`ifdef CU_ENC_CHECK_EN
      chk_err    <= 1'b0;
`endif
    end else if (clear) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      im_we      <= 1'b0;
      im_addr    <= '0;
      enc_err    <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
`ifdef CU_ENC_CHECK_EN
      chk_err    <= 1'b0;
`endif
    end else begin
      enc_err <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          req_q     <= '{kind: req_kind, cond: req_cond, cmd: req_cmd, s: req_s,
                         rn: req_rn, rd: req_rd, rm: req_rm, imm: req_imm};
          req_ready <= 1'b0;
          state     <= S_ENC;
        end
        S_ENC: begin
          im_wdata <= enc_word;
          if (enc_illegal) begin
            enc_err   <= 1'b1;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            im_we <= 1'b1;
            state <= S_WR;
          end
        end
        S_WR: begin
`ifdef CU_ENC_CHECK_EN
          if (chk_bad) chk_err <= 1'b1;
`endif
          if (im_wr_ready) begin
            im_we      <= 1'b0;
            word_count <= word_count + (ADDR_W+1)'(1);
            // Last slot: address holds so it never wraps back over word 0.
            if (im_addr == ADDR_W'(DEPTH-1)) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              im_addr   <= im_addr + ADDR_W'(1);
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_FULL: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_instr_encoder.sv
// Directed self-checking bench for cu_instr_encoder (default DEPTH=64).
module tb_cu_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = '0;
  logic [3:0]  req_cond = '0;
  logic [3:0]  req_cmd = '0;
  logic        req_s = 1'b0;
  logic [3:0]  req_rn = '0;
  logic [3:0]  req_rd = '0;
  logic [3:0]  req_rm = '0;
  logic [23:0] req_imm = '0;
  logic        im_we;
  logic [5:0]  im_addr;
  logic [31:0] im_wdata;
  logic        im_wr_ready = 1'b1;
  logic        enc_err;
  logic        full;
  logic [6:0]  word_count;
`ifdef CU_ENC_CHECK_EN
  logic        chk_err;
`endif

  int checks = 0;
  int errors = 0;

  cu_instr_encoder #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_cond(req_cond), .req_cmd(req_cmd), .req_s(req_s),
    .req_rn(req_rn), .req_rd(req_rd), .req_rm(req_rm), .req_imm(req_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_wr_ready(im_wr_ready),
    .enc_err(enc_err), .full(full), .word_count(word_count)
`ifdef CU_ENC_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  // Presents one request for one cycle; caller ensures the encoder is idle.
  task automatic send(input logic [2:0] kind, input logic [3:0] cond, input logic [3:0] cmd,
                      input logic [3:0] rn, input logic [3:0] rd, input logic [3:0] rm,
                      input logic [23:0] imm);
    @(negedge clk);
    req_kind = kind; req_cond = cond; req_cmd = cmd; req_s = 1'b0;
    req_rn = rn; req_rd = rd; req_rm = rm; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (im_we) ok = 1'b1;
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", im_we); end
    checks++; if (im_addr !== 6'd0 || im_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_data got %h/%h want 0/0", im_addr, im_wdata); end
    checks++; if (enc_err !== 1'b0 || full !== 1'b0 || word_count !== 7'd0) begin errors++; $display("FAIL rst_flags got %b %b %0d want 0 0 0", enc_err, full, word_count); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_dp_reg();
    im_wr_ready = 1'b1;
    send(3'd0, 4'hE, 4'b0100, 4'd2, 4'd1, 4'd3, 24'h0);
    checks++; if (im_we !== 1'b0) begin errors++; $display("FAIL dpreg_we_early got %b want 0", im_we); end
    @(posedge clk); #1;
    checks++; if (im_we !== 1'b1) begin errors++; $display("FAIL dpreg_we_latency got %b want 1", im_we); end
    checks++; if (im_wdata !== 32'hE0821003) begin errors++; $display("FAIL dpreg_word got %h want E0821003", im_wdata); end
    checks++; if (im_addr !== 6'd0) begin errors++; $display("FAIL dpreg_addr got %0d want 0", im_addr); end
    @(posedge clk); #1;
    checks++; if (im_we !== 1'b0 || word_count !== 7'd1 || req_ready !== 1'b1) begin errors++; $display("FAIL dpreg_done got we=%b cnt=%0d rdy=%b want 0 1 1", im_we, word_count, req_ready); end
  endtask

  task automatic test_kinds();
    logic [2:0]  kinds [4] = '{3'd1, 3'd3, 3'd2, 3'd4};
    logic [3:0]  cmds  [4] = '{4'b0010, 4'd0, 4'd0, 4'd0};
    logic [3:0]  rns   [4] = '{4'd4, 4'd1, 4'd1, 4'd0};
    logic [3:0]  rds   [4] = '{4'd4, 4'd0, 4'd0, 4'd0};
    logic [23:0] imms  [4] = '{24'h1, 24'h4, 24'h4, 24'h2};
    logic [31:0] exps  [4] = '{32'hE2444001, 32'hE5910004, 32'hE5810004, 32'hEA000002};
    bit ok;
    do_clear();
    im_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(kinds[i], 4'hE, cmds[i], rns[i], rds[i], 4'd0, imms[i]);
      wait_we(ok);
      checks++; if (!ok) begin errors++; $display("FAIL kinds_timeout idx %0d got no im_we want im_we", i); end
      checks++; if (im_wdata !== exps[i]) begin errors++; $display("FAIL kinds_word idx %0d got %h want %h", i, im_wdata, exps[i]); end
      checks++; if (im_addr !== 6'(i)) begin errors++; $display("FAIL kinds_addr idx %0d got %0d want %0d", i, im_addr, i); end
      @(posedge clk); #1;
    end
    checks++; if (word_count !== 7'd4) begin errors++; $display("FAIL kinds_count got %0d want 4", word_count); end
  endtask

  task automatic test_backpressure();
    bit ok;
    im_wr_ready = 1'b0;
    send(3'd0, 4'h0, 4'hF, 4'd5, 4'd6, 4'd7, 24'h0);
    wait_we(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got no im_we want im_we"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (im_we !== 1'b1 || im_addr !== 6'd4 || im_wdata !== 32'h01E56007 || word_count !== 7'd4) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got we=%b addr=%0d data=%h cnt=%0d want 1 4 01E56007 4", i, im_we, im_addr, im_wdata, word_count);
      end
    end
    @(negedge clk); im_wr_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (im_we !== 1'b0 || im_addr !== 6'd5 || word_count !== 7'd5) begin errors++; $display("FAIL bp_release got we=%b addr=%0d cnt=%0d want 0 5 5", im_we, im_addr, word_count); end
  endtask

  task automatic test_illegal();
    send(3'd6, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0);
    checks++; if (req_ready !== 1'b0 || enc_err !== 1'b0) begin errors++; $display("FAIL ill_accept got rdy=%b err=%b want 0 0", req_ready, enc_err); end
    @(posedge clk); #1;
    checks++; if (enc_err !== 1'b1 || req_ready !== 1'b1 || im_we !== 1'b0) begin errors++; $display("FAIL ill_pulse got err=%b rdy=%b we=%b want 1 1 0", enc_err, req_ready, im_we); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (enc_err !== 1'b0 || im_we !== 1'b0 || word_count !== 7'd5) begin errors++; $display("FAIL ill_after cyc %0d got err=%b we=%b cnt=%0d want 0 0 5", i, enc_err, im_we, word_count); end
    end
  endtask

  task automatic test_full();
    bit ok;
    do_clear();
    im_wr_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send(3'd1, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 24'(i));
      wait_we(ok);
      checks++; if (!ok || im_addr !== 6'(i)) begin errors++; $display("FAIL full_fill idx %0d got ok=%b addr=%0d want 1 %0d", i, ok, im_addr, i); end
      @(posedge clk); #1;
    end
    checks++; if (full !== 1'b1 || word_count !== 7'd64 || req_ready !== 1'b0) begin errors++; $display("FAIL full_state got full=%b cnt=%0d rdy=%b want 1 64 0", full, word_count, req_ready); end
    @(negedge clk); req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b0 || im_we !== 1'b0 || word_count !== 7'd64) begin errors++; $display("FAIL full_block cyc %0d got rdy=%b we=%b cnt=%0d want 0 0 64", i, req_ready, im_we, word_count); end
    end
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1;
    checks++; if (full !== 1'b0 || word_count !== 7'd0 || im_addr !== 6'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL full_clear got full=%b cnt=%0d addr=%0d rdy=%b want 0 0 0 1", full, word_count, im_addr, req_ready); end
    @(negedge clk); clear = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clear_beats_req got rdy=%b want 1", req_ready); end
    send(3'd4, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000010);
    wait_we(ok);
    checks++; if (!ok || im_addr !== 6'd0 || im_wdata !== 32'hEA000010) begin errors++; $display("FAIL full_restart got ok=%b addr=%0d data=%h want 1 0 EA000010", ok, im_addr, im_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    bit ok;
    im_wr_ready = 1'b0;
    send(3'd0, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0);
    wait_we(ok);
    checks++; if (!ok || im_addr !== 6'd1) begin errors++; $display("FAIL abort_clr_setup got ok=%b addr=%0d want 1 1", ok, im_addr); end
    @(negedge clk); clear = 1'b1; im_wr_ready = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    checks++; if (im_we !== 1'b0 || im_addr !== 6'd0 || word_count !== 7'd0) begin errors++; $display("FAIL abort_clear got we=%b addr=%0d cnt=%0d want 0 0 0", im_we, im_addr, word_count); end
    im_wr_ready = 1'b0;
    send(3'd0, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0);
    wait_we(ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_rst_setup got no im_we want im_we"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (im_we !== 1'b0 || im_addr !== 6'd0 || word_count !== 7'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_rst got we=%b addr=%0d cnt=%0d rdy=%b want 0 0 0 1", im_we, im_addr, word_count, req_ready); end
    @(negedge clk); rst = 1'b0; im_wr_ready = 1'b1;
  endtask

`ifdef CU_ENC_CHECK_EN
  task automatic test_check();
    bit ok;
    im_wr_ready = 1'b0;
    send(3'd3, 4'hE, 4'd0, 4'd1, 4'd0, 4'd0, 24'h4);
    wait_we(ok);
    checks++; if (!ok || chk_err !== 1'b0) begin errors++; $display("FAIL chk_clean got ok=%b chk=%b want 1 0", ok, chk_err); end
    force dut.im_wdata[20] = 1'b0;
    @(posedge clk); #1;
    release dut.im_wdata[20];
    checks++; if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_detect got %b want 1", chk_err); end
    do_clear();
    checks++; if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_clear got %b want 0", chk_err); end
    im_wr_ready = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_dp_reg();
    test_kinds();
    test_backpressure();
    test_illegal();
    test_full();
    test_abort();
`ifdef CU_ENC_CHECK_EN
    test_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
